ifetch_ctrl: RTL

Instruction-fetch sequencer between the PC register and the SRAM-like instruction bus (req/addr_ok/data_ok).
- Latches the current PC, issues exactly one bus request per instruction and buffers the returned word for decode.
- Drives the inst_stall bit (stall[0]) that freezes the PC while a fetch is in flight.
- On flush (exception or branch redirect), discards any in-flight response so stale instructions never reach decode.

---
 rtl/ifetch_ctrl_if.sv | 27 ++
 rtl/ifetch_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl_if.sv
// ifetch_ctrl_if: SRAM-like instruction bus (req / addr_ok / data_ok) between the
// fetch sequencer and instruction memory.
//   master (fetch side): drives inst_req, inst_addr; samples addr_ok, data_ok, rdata
//   slave  (memory side): samples inst_req, inst_addr; drives addr_ok, data_ok, rdata
interface ifetch_ctrl_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer between the PC register and the
// instruction bus. One bus request per instruction, one transaction outstanding,
// the returned word buffered for decode. A flush discards any in-flight response.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   pc_i            current PC
//   flush_i         exception / branch redirect this cycle
//   pipe_stall_i    decode cannot accept the buffered instruction
//   bus             instruction bus, master side
//   inst_o          fetched instruction (NOP_INST when the fetch was suppressed)
//   inst_pc_o       PC of inst_o
//   inst_valid_o    inst_o / inst_pc_o valid
//   inst_stall_o    freezes the PC while no instruction is ready
//   adel_o          fetch suppressed because the PC was misaligned
//
// Optional feature, enabled by defining IFETCH_PERF_EN:
//   perf_stall_cnt    cycles spent stalled in REQ or WAIT (wraps)
//   perf_discard_cnt  dropped responses (saturates)
module ifetch_ctrl #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pc_i,
  input  logic                flush_i,
  input  logic                pipe_stall_i,
  ifetch_ctrl_if.master       bus,
  output logic [31:0]         inst_o,
  output logic [31:0]         inst_pc_o,
  output logic                inst_valid_o,
  output logic                inst_stall_o,
  output logic                adel_o
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]         perf_stall_cnt,
  output logic [15:0]         perf_discard_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StReady} state_e;

  state_e      state_q;
  logic [31:0] req_addr_q;
  logic        discard_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        adel_q;

  // Response arriving in WAIT that must not reach decode.
  logic resp_drop;
  assign resp_drop = (state_q == StWait) && bus.inst_data_ok && (discard_q || flush_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      req_addr_q <= 32'h0;
      discard_q  <= 1'b0;
      inst_q     <= NOP_INST;
      inst_pc_q  <= 32'h0;
      adel_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // pc_i is stale during a flush; wait for the redirected PC.
          if (!flush_i) begin
            if (pc_i[1:0] != 2'b00) begin
              inst_q    <= NOP_INST;
              inst_pc_q <= pc_i;
              adel_q    <= 1'b1;
              state_q   <= StReady;
            end else begin
              req_addr_q <= pc_i;
              state_q    <= StReq;
            end
          end
        end
        StReq: begin
          // A request cannot be withdrawn; a flush only marks its response stale.
          if (flush_i) begin
            discard_q <= 1'b1;
          end
          if (bus.inst_addr_ok) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (bus.inst_data_ok) begin
            if (discard_q || flush_i) begin
              discard_q <= 1'b0;
              state_q   <= StIdle;
            end else begin
              inst_q    <= bus.inst_rdata;
              inst_pc_q <= req_addr_q;
              adel_q    <= 1'b0;
              state_q   <= StReady;
            end
          end else if (flush_i) begin
            discard_q <= 1'b1;
          end
        end
        StReady: begin
          // Leave on flush (word dropped) or when decode takes the word.
          if (flush_i || !pipe_stall_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.inst_req  = (state_q == StReq);
  assign bus.inst_addr = req_addr_q;

  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign adel_o       = adel_q;
  assign inst_valid_o = (state_q == StReady);
  assign inst_stall_o = (state_q != StReady);

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_stall_q;
  logic [15:0] perf_discard_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q   <= 32'h0;
      perf_discard_q <= 16'h0;
    end else begin
      if (inst_stall_o && (state_q == StReq || state_q == StWait)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (resp_drop && (perf_discard_q != 16'hFFFF)) begin
        perf_discard_q <= perf_discard_q + 16'd1;
      end
    end
  end

  assign perf_stall_cnt   = perf_stall_q;
  assign perf_discard_cnt = perf_discard_q;
`else
  // Without the counters resp_drop has no consumer.
  logic unused_resp_drop;
  assign unused_resp_drop = resp_drop;
`endif

endmodule
